// File: rtl/chiplet_types_pkg.sv
// rtl/chiplet_types_pkg.sv - shared flit, queue-entry and transmitter state types
package chiplet_types_pkg;

    localparam int VC_W      = 2;
    localparam int DEST_W    = 4;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [VC_W-1:0]   vc;
    } flit_meta_t;

    typedef struct packed {
        flit_meta_t             metadata;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;

    // One queued flit plus its end-of-packet marker
    typedef struct packed {
        flit_t flit;
        logic  last;
    } tx_entry_t;

    typedef enum logic {
        TX_IDLE,
        TX_LOCKED
    } tx_state_t;

endpackage

// File: rtl/tx_vc_fifo.sv
// rtl/tx_vc_fifo.sv - per-VC synchronous queue of flits with last markers
module tx_vc_fifo
    import chiplet_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  tx_entry_t                push_data,
    input  logic                     pop,
    output tx_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    tx_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/switch_port_tx.sv
// rtl/switch_port_tx.sv - credit-based per-VC transmitter feeding one switch ingress port
module switch_port_tx
    import chiplet_types_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            host_valid,
    input  flit_t                                           host_flit,
    input  logic                                            host_last,
    output logic                                            host_ready,
    input  logic [NUM_VCS-1:0]                              credit_return,
    output logic                                            data_ready_out,
    output flit_t                                           flit_out,
    output logic [NUM_VCS-1:0][$clog2(BUFFER_SIZE+1)-1:0]   credits,
    output logic                                            credit_err,
    output logic                                            busy
);

    localparam int CW    = $clog2(BUFFER_SIZE + 1);
    localparam int VW    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t          state;
    logic [VW-1:0]      lock_vc;
    logic [VW-1:0]      rr_ptr;

    logic [NUM_VCS-1:0] fifo_full;
    logic [NUM_VCS-1:0] fifo_empty;
    logic [NUM_VCS-1:0] push;
    logic [NUM_VCS-1:0] pop;
    logic [NUM_VCS-1:0] eligible;
    logic [NUM_VCS-1:0] credit_over;
    logic [CNT_W-1:0]   fifo_count [NUM_VCS];
    tx_entry_t          fifo_head  [NUM_VCS];

    tx_entry_t          host_entry;
    logic [VW-1:0]      host_vc;
    logic               host_vc_ok;

    logic               pick_found;
    logic [VW-1:0]      pick_vc;
    logic               send;
    logic [VW-1:0]      send_vc;
    tx_entry_t          send_entry;

    assign host_entry = {host_flit, host_last};
    assign host_vc    = host_flit.metadata.vc[VW-1:0];
    assign host_vc_ok = int'(host_flit.metadata.vc) < NUM_VCS;
    assign host_ready = host_vc_ok && !fifo_full[host_vc];

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign push[v]        = host_valid && host_ready && (host_vc == VW'(v));
        assign pop[v]         = send && (send_vc == VW'(v));
        assign eligible[v]    = !fifo_empty[v] && (credits[v] != '0);
        assign credit_over[v] = credit_return[v] && !pop[v] && (credits[v] == CW'(BUFFER_SIZE));

        tx_vc_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[v]),
            .push_data (host_entry),
            .pop       (pop[v]),
            .head      (fifo_head[v]),
            .full      (fifo_full[v]),
            .empty     (fifo_empty[v]),
            .count     (fifo_count[v])
        );
    end

    // Round-robin search starting one past the last VC that won arbitration
    always_comb begin
        logic [VW-1:0] cand;
        pick_found = 1'b0;
        pick_vc    = rr_ptr;
        cand       = '0;
        for (int i = 1; i <= NUM_VCS; i++) begin
            cand = VW'((int'(rr_ptr) + i) % NUM_VCS);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_vc    = cand;
            end
        end
    end

    // While a packet is open only its own VC may send; otherwise arbitration decides
    always_comb begin
        send    = 1'b0;
        send_vc = lock_vc;
        if (state == TX_LOCKED) begin
            send    = eligible[lock_vc];
            send_vc = lock_vc;
        end else begin
            send    = pick_found;
            send_vc = pick_vc;
        end
    end

    assign send_entry = fifo_head[send_vc];

    // Packet-lock FSM with registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= TX_IDLE;
            lock_vc        <= '0;
            rr_ptr         <= VW'(NUM_VCS - 1);
            data_ready_out <= 1'b0;
            flit_out       <= '0;
        end else begin
            data_ready_out <= send;
            if (send) begin
                flit_out <= send_entry.flit;
            end
            case (state)
                TX_IDLE: begin
                    if (send) begin
                        rr_ptr <= send_vc;
                        if (!send_entry.last) begin
                            state   <= TX_LOCKED;
                            lock_vc <= send_vc;
                        end
                    end
                end
                TX_LOCKED: begin
                    if (send && send_entry.last) begin
                        state <= TX_IDLE;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

    // Credit counters: a send and a return on the same edge cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credits[v] <= CW'(BUFFER_SIZE);
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (pop[v] && !credit_return[v]) begin
                    credits[v] <= credits[v] - CW'(1);
                end else if (!pop[v] && credit_return[v] && !credit_over[v]) begin
                    credits[v] <= credits[v] + CW'(1);
                end
            end
        end
    end

    // Sticky flag for a credit returned into an already-full counter
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (|credit_over) begin
            credit_err <= 1'b1;
        end
    end

    // Activity indication
    always_comb begin
        busy = (state == TX_LOCKED) || data_ready_out;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (fifo_count[v] != '0) begin
                busy = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_switch_port_tx.sv
// tb/tb_switch_port_tx.sv - self-checking bench with queue-based reference model
module tb_switch_port_tx;
    import chiplet_types_pkg::*;

    localparam int NV = 2;
    localparam int BS = 8;
    localparam int FD = 4;
    localparam int CW = $clog2(BS + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   host_valid;
    flit_t                  host_flit;
    logic                   host_last;
    logic                   host_ready;
    logic [NV-1:0]          credit_return;
    logic                   data_ready_out;
    flit_t                  flit_out;
    logic [NV-1:0][CW-1:0]  credits;
    logic                   credit_err;
    logic                   busy;

    always #5 clk = ~clk;

    switch_port_tx #(
        .NUM_VCS     (NV),
        .BUFFER_SIZE (BS),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_valid     (host_valid),
        .host_flit      (host_flit),
        .host_last      (host_last),
        .host_ready     (host_ready),
        .credit_return  (credit_return),
        .data_ready_out (data_ready_out),
        .flit_out       (flit_out),
        .credits        (credits),
        .credit_err     (credit_err),
        .busy           (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    flit_t      mq [NV][$];
    bit         lq [NV][$];
    int         mcred [NV];
    bit         merr;
    bit         mlocked;
    int         mlock;
    int         mrr;
    bit         mdro;
    flit_t      mflit;

    bit [NV-1:0] refill_en;
    bit          last_acc;
    int          dut_log [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            lq[v].delete();
            mcred[v] = BS;
        end
        merr    = 1'b0;
        mlocked = 1'b0;
        mlock   = 0;
        mrr     = NV - 1;
        mdro    = 1'b0;
        mflit   = '0;
    endtask

    function automatic int count_vc(input int vc);
        int n = 0;
        foreach (dut_log[k]) if (dut_log[k] == vc) n++;
        return n;
    endfunction

    task automatic drive(input bit v, input int vc, input bit last, input logic [NV-1:0] cr);
        host_valid             = v;
        host_flit.metadata.vc  = VC_W'(vc);
        host_flit.metadata.dest = DEST_W'($urandom);
        host_flit.payload      = $urandom;
        host_last              = last;
        credit_return          = cr;
    endtask

    // One clock: check host_ready, advance the model, then compare all outputs
    task automatic step();
        bit m_ready;
        bit snd;
        bit lst;
        bit anyq;
        int sv;
        int hv;
        for (int v = 0; v < NV; v++) begin
            if (refill_en[v]) credit_return[v] = (mcred[v] < BS);
        end
        #1;
        hv = int'(host_flit.metadata.vc);
        m_ready = 1'b0;
        if (hv < NV) m_ready = (mq[hv].size() < FD);
        if (!rst) chk("host_ready", 64'(host_ready), 64'(m_ready));
        last_acc = 1'b0;
        if (rst) begin
            @(posedge clk);
            model_reset();
        end else begin
            snd = 1'b0;
            sv  = 0;
            lst = 1'b0;
            if (mlocked) begin
                if (mq[mlock].size() > 0 && mcred[mlock] > 0) begin
                    snd = 1'b1;
                    sv  = mlock;
                end
            end else begin
                for (int i = 1; i <= NV; i++) begin
                    int c;
                    c = (mrr + i) % NV;
                    if (!snd && mq[c].size() > 0 && mcred[c] > 0) begin
                        snd = 1'b1;
                        sv  = c;
                    end
                end
            end
            for (int v = 0; v < NV; v++) begin
                bit d;
                d = snd && (sv == v);
                if (d && !credit_return[v]) mcred[v]--;
                else if (!d && credit_return[v]) begin
                    if (mcred[v] == BS) merr = 1'b1;
                    else mcred[v]++;
                end
            end
            mdro = snd;
            if (snd) begin
                mflit = mq[sv].pop_front();
                lst   = lq[sv].pop_front();
                if (!mlocked) mrr = sv;
                mlocked = !lst;
                mlock   = sv;
            end
            last_acc = host_valid && m_ready;
            if (last_acc) begin
                mq[hv].push_back(host_flit);
                lq[hv].push_back(host_last);
            end
            @(posedge clk);
        end
        #1;
        if (data_ready_out === 1'b1) dut_log.push_back(int'(flit_out.metadata.vc));
        anyq = mlocked || mdro;
        for (int v = 0; v < NV; v++) if (mq[v].size() > 0) anyq = 1'b1;
        chk("data_ready_out", 64'(data_ready_out), 64'(mdro));
        chk("flit_out", 64'(flit_out), 64'(mflit));
        for (int v = 0; v < NV; v++) chk("credits", 64'(credits[v]), 64'(mcred[v]));
        chk("credit_err", 64'(credit_err), 64'(merr));
        chk("busy", 64'(busy), 64'(anyq));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 1'b0, '0);
            step();
        end
    endtask

    task automatic push_flit(input int vc, input bit last);
        int n = 0;
        do begin
            drive(1'b1, vc, last, '0);
            step();
            n++;
        end while (!last_acc && n < 50);
        chk("push_accept", 64'(last_acc), 64'(1));
    endtask

    initial begin
        int exp_seq [4] = '{0, 0, 0, 1};
        logic [31:0] exp_payload;
        int bad;

        model_reset();
        refill_en = '0;
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, '0);
        step();
        step();
        rst = 1'b0;
        chk("rst_credits0", 64'(credits[0]), 64'(8));
        chk("rst_credits1", 64'(credits[1]), 64'(8));
        chk("rst_dro", 64'(data_ready_out), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(credit_err), 64'(0));
        chk("rst_flit", 64'(flit_out), 64'(0));

        // Single-flit packet: two-cycle latency, one credit consumed
        drive(1'b1, 0, 1'b1, '0);
        exp_payload = host_flit.payload;
        step();
        chk("single_lat1_dro", 64'(data_ready_out), 64'(0));
        drive(1'b0, 0, 1'b0, '0);
        step();
        chk("single_lat2_dro", 64'(data_ready_out), 64'(1));
        chk("single_payload", 64'(flit_out.payload), 64'(exp_payload));
        chk("single_credit", 64'(credits[0]), 64'(7));
        drive(1'b0, 0, 1'b0, 2'b01);
        step();
        chk("single_credit_back", 64'(credits[0]), 64'(8));

        // Credit exhaustion on VC1
        dut_log.delete();
        repeat (10) push_flit(1, 1'b1);
        idle(10);
        chk("exhaust_sent", 64'(count_vc(1)), 64'(8));
        chk("exhaust_credits", 64'(credits[1]), 64'(0));
        drive(1'b0, 0, 1'b0, 2'b10);
        step();
        idle(4);
        chk("release_one", 64'(count_vc(1)), 64'(9));
        refill_en[1] = 1'b1;
        idle(12);
        chk("exhaust_drained", 64'(count_vc(1)), 64'(10));
        chk("exhaust_refilled", 64'(credits[1]), 64'(8));

        // Packet contiguity with VC0 starved mid-packet
        repeat (7) push_flit(0, 1'b1);
        idle(5);
        chk("contig_credit1", 64'(credits[0]), 64'(1));
        dut_log.delete();
        push_flit(0, 1'b0);
        push_flit(0, 1'b0);
        push_flit(0, 1'b1);
        push_flit(1, 1'b1);
        idle(5);
        drive(1'b0, 0, 1'b0, 2'b01);
        step();
        refill_en[0] = 1'b1;
        idle(10);
        chk("contig_len", 64'(dut_log.size()), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (k < dut_log.size()) chk("contig_order", 64'(dut_log[k]), 64'(exp_seq[k]));
        end

        // Round-robin with both queues backlogged
        refill_en = '0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, i % 2, 1'b1, '0);
            step();
        end
        chk("rr_preload_c0", 64'(credits[0]), 64'(0));
        chk("rr_preload_c1", 64'(credits[1]), 64'(0));
        dut_log.delete();
        refill_en = '1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, i % 2, 1'b1, '0);
            step();
        end
        idle(30);
        chk("rr_count", 64'(dut_log.size() >= 20), 64'(1));
        bad = 0;
        for (int k = 1; k < 20; k++) begin
            if (k < dut_log.size() && dut_log[k] == dut_log[k-1]) bad++;
        end
        chk("rr_alternate", 64'(bad), 64'(0));

        // Credit edge cases on VC0
        refill_en[0] = 1'b0;
        idle(2);
        chk("edge_pre_credit", 64'(credits[0]), 64'(8));
        drive(1'b1, 0, 1'b1, '0);
        step();
        drive(1'b0, 0, 1'b0, 2'b01);
        step();
        chk("same_edge_dro", 64'(data_ready_out), 64'(1));
        chk("same_edge_credit", 64'(credits[0]), 64'(8));
        chk("same_edge_err", 64'(credit_err), 64'(0));
        drive(1'b0, 0, 1'b0, 2'b01);
        step();
        chk("over_credit", 64'(credits[0]), 64'(8));
        chk("over_err", 64'(credit_err), 64'(1));
        idle(3);
        chk("over_err_sticky", 64'(credit_err), 64'(1));
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, '0);
        step();
        rst = 1'b0;
        chk("err_cleared", 64'(credit_err), 64'(0));

        // Reset with two of three flits sent
        refill_en[0] = 1'b0;
        push_flit(0, 1'b0);
        push_flit(0, 1'b0);
        drive(1'b0, 0, 1'b0, '0);
        step();
        chk("mid_credit", 64'(credits[0]), 64'(6));
        chk("mid_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, '0);
        step();
        rst = 1'b0;
        chk("mid_rst_dro", 64'(data_ready_out), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_credit0", 64'(credits[0]), 64'(8));
        chk("mid_rst_credit1", 64'(credits[1]), 64'(8));
        chk("mid_rst_flit", 64'(flit_out), 64'(0));
        dut_log.delete();
        idle(10);
        chk("post_rst_quiet", 64'(dut_log.size()), 64'(0));

        // Randomized traffic against the model
        refill_en = '0;
        for (int i = 0; i < 3000; i++) begin
            logic [NV-1:0] cr;
            int vc;
            cr = '0;
            for (int v = 0; v < NV; v++) begin
                if (mcred[v] < BS) cr[v] = ($urandom_range(0, 2) == 0);
                else cr[v] = ($urandom_range(0, 499) == 0);
            end
            vc = ($urandom_range(0, 15) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
            drive($urandom_range(0, 9) < 7, vc, $urandom_range(0, 2) == 0, cr);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
